// File: rtl/regfile_sb.sv
// regfile_sb: XLEN x NREGS integer register file with an in-order issue
// scoreboard (one busy bit per register).
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   rd_sel        NRD packed read selects, port k at [k*AW +: AW]
//   rd_data       NRD packed read data, port k at [k*XLEN +: XLEN]
//   rd_busy       busy bit of each selected register
//   wr_en/sel/data  writeback port (writes data, releases busy)
//   rsv_en/sel    issue reserve port (marks destination busy)
//   busy_any      OR of all busy bits
//   rsv_conflict  registered WAW flag: reserve hit an already-busy register
//
// Optional: define REGFILE_SB_BYPASS_EN for same-cycle write-through reads.

module regfile_sb #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NRD*$clog2(NREGS)-1:0]  rd_sel,
    output logic [NRD*XLEN-1:0]           rd_data,
    output logic [NRD-1:0]                rd_busy,
    input  logic                          wr_en,
    input  logic [$clog2(NREGS)-1:0]      wr_sel,
    input  logic [XLEN-1:0]               wr_data,
    input  logic                          rsv_en,
    input  logic [$clog2(NREGS)-1:0]      rsv_sel,
    output logic                          busy_any,
    output logic                          rsv_conflict
);

    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;

    logic wr_zero;
    logic rsv_zero;
    logic wr_ok;
    logic rsv_ok;
    logic conflict_nxt;

    // Register 0 is hard-wired when ZERO_REG is set: its write and
    // reserve requests are dropped before touching any state.
    assign wr_zero  = (ZERO_REG != 0) && (wr_sel == '0);
    assign rsv_zero = (ZERO_REG != 0) && (rsv_sel == '0);

    // Enables gate the selects so X on an idle select cannot leak in.
    assign wr_ok  = wr_en  & ~wr_zero;
    assign rsv_ok = rsv_en & ~rsv_zero;

    // Release first, then reserve: a same-register write+reserve leaves
    // the register busy because the new producer wins.
    always_comb begin
        busy_nxt = busy;
        if (wr_ok) begin
            busy_nxt[wr_sel] = 1'b0;
        end
        if (rsv_ok) begin
            busy_nxt[rsv_sel] = 1'b1;
        end
    end

    // WAW hit on pre-edge state, unless the same edge retires the
    // old producer of that register.
    always_comb begin
        conflict_nxt = 1'b0;
        if (rsv_ok && busy[rsv_sel]) begin
            conflict_nxt = ~(wr_ok && (wr_sel == rsv_sel));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[wr_sel] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy         <= '0;
            rsv_conflict <= 1'b0;
        end else begin
            busy         <= busy_nxt;
            rsv_conflict <= conflict_nxt;
        end
    end

    assign busy_any = |busy;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   sel;
        logic [XLEN-1:0] data;
        logic            bsy;

        assign sel = rd_sel[k*AW +: AW];

        always_comb begin
            data = regs[sel];
            bsy  = busy[sel];
`ifdef REGFILE_SB_BYPASS_EN
            // wr_ok already excludes register 0 when it is hard-wired.
            if (wr_ok && (wr_sel == sel)) begin
                data = wr_data;
                bsy  = 1'b0;
            end
`endif
            if ((ZERO_REG != 0) && (sel == '0)) begin
                data = '0;
                bsy  = 1'b0;
            end
        end

        assign rd_data[k*XLEN +: XLEN] = data;
        assign rd_busy[k]              = bsy;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: random + directed scoreboard bench for regfile_sb.
// Drives two instances (ZERO_REG=1/NRD=2 and ZERO_REG=0/NRD=4) in lockstep.

module tb_regfile_sb;

    localparam int XL = 32;
    localparam int NR = 32;
    localparam int AW = 5;

    logic            clk;
    logic            rst_n;
    logic [4*AW-1:0] rsel;
    logic            wr_en;
    logic [AW-1:0]   wr_sel;
    logic [XL-1:0]   wr_data;
    logic            rsv_en;
    logic [AW-1:0]   rsv_sel;

    logic [2*XL-1:0] z_data;
    logic [1:0]      z_busy;
    logic            z_any;
    logic            z_cf;
    logic [4*XL-1:0] n_data;
    logic [3:0]      n_busy;
    logic            n_any;
    logic            n_cf;

    regfile_sb #(.XLEN(XL), .NREGS(NR), .NRD(2), .ZERO_REG(1)) u_z (
        .clk(clk), .rst_n(rst_n),
        .rd_sel(rsel[2*AW-1:0]), .rd_data(z_data), .rd_busy(z_busy),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_sel(rsv_sel),
        .busy_any(z_any), .rsv_conflict(z_cf)
    );

    regfile_sb #(.XLEN(XL), .NREGS(NR), .NRD(4), .ZERO_REG(0)) u_n (
        .clk(clk), .rst_n(rst_n),
        .rd_sel(rsel), .rd_data(n_data), .rd_busy(n_busy),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_sel(rsv_sel),
        .busy_any(n_any), .rsv_conflict(n_cf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4*XL-1:0] dn;
        logic [3:0]      bn;
        logic            an;
        logic            cn;
        logic [2*XL-1:0] dz;
        logic [1:0]      bz;
        logic            az;
        logic            cz;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: index 0 = ZERO_REG instance, 1 = ordinary.
    logic [XL-1:0] m_reg  [2][NR];
    bit            m_busy [2][NR];
    bit            m_cf   [2];
    bit            zr     [2] = '{1'b1, 1'b0};

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int r = 0; r < NR; r++) begin
                m_reg[d][r]  = '0;
                m_busy[d][r] = 1'b0;
            end
            m_cf[d] = 1'b0;
        end
    endfunction

    function automatic bit wok(int d);
        return wr_en && !(zr[d] && wr_sel == 0);
    endfunction

    // Applies the inputs held across a rising edge.
    function automatic void model_step();
        for (int d = 0; d < 2; d++) begin
            bit w;
            bit r;
            w = wok(d);
            r = rsv_en && !(zr[d] && rsv_sel == 0);
            m_cf[d] = r && m_busy[d][rsv_sel]
                      && !(wr_en && wr_sel == rsv_sel);
            if (w) begin
                m_reg[d][wr_sel]  = wr_data;
                m_busy[d][wr_sel] = 1'b0;
            end
            if (r) m_busy[d][rsv_sel] = 1'b1;
        end
    endfunction

    function automatic void port_exp(int d, int s,
                                     output logic [XL-1:0] dv,
                                     output logic bv);
        dv = m_reg[d][s];
        bv = m_busy[d][s];
`ifdef REGFILE_SB_BYPASS_EN
        if (wok(d) && wr_sel == s) begin
            dv = wr_data;
            bv = 1'b0;
        end
`endif
        if (zr[d] && s == 0) begin
            dv = '0;
            bv = 1'b0;
        end
    endfunction

    function automatic void push_exp();
        exp_t e;
        logic [XL-1:0] dv;
        logic bv;
        e.dn = '0; e.bn = '0; e.dz = '0; e.bz = '0;
        for (int k = 0; k < 4; k++) begin
            port_exp(1, int'(rsel[k*AW +: AW]), dv, bv);
            e.dn[k*XL +: XL] = dv;
            e.bn[k] = bv;
        end
        for (int k = 0; k < 2; k++) begin
            port_exp(0, int'(rsel[k*AW +: AW]), dv, bv);
            e.dz[k*XL +: XL] = dv;
            e.bz[k] = bv;
        end
        e.an = 1'b0;
        e.az = 1'b0;
        for (int r = 0; r < NR; r++) begin
            e.an |= m_busy[1][r];
            e.az |= m_busy[0][r];
        end
        e.cn = m_cf[1];
        e.cz = m_cf[0];
        q.push_back(e);
    endfunction

    task automatic chk(string nm, logic [4*XL-1:0] a,
                       logic [4*XL-1:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, a, e, $time);
        end
    endtask

    // Monitor: outputs are combinational/registered, sampled mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("n_data", n_data, e.dn);
            chk("n_busy", n_busy, e.bn);
            chk("n_any",  n_any,  e.an);
            chk("n_conf", n_cf,   e.cn);
            chk("z_data", z_data, e.dz);
            chk("z_busy", z_busy, e.bz);
            chk("z_any",  z_any,  e.az);
            chk("z_conf", z_cf,   e.cz);
        end
    end

    task automatic cyc(input logic we, input logic [AW-1:0] ws,
                       input logic [XL-1:0] wd, input logic re,
                       input logic [AW-1:0] rs,
                       input logic [4*AW-1:0] rd, input bit do_rst,
                       input bit xsel);
        @(posedge clk);
        #1;
        if (rst_n) model_step();
        wr_en   = we;
        wr_sel  = (!we && xsel) ? 'x : ws;
        wr_data = wd;
        rsv_en  = re;
        rsv_sel = (!re && xsel) ? 'x : rs;
        rsel    = rd;
        if (do_rst) begin
            #1;
            rst_n = 1'b0;
            model_reset();
        end
        push_exp();
        if (do_rst) begin
            #5;
            rst_n = 1'b1;
        end
    endtask

    function automatic logic [4*AW-1:0] p4(int a, int b, int c, int d);
        logic [AW-1:0] s0, s1, s2, s3;
        s0 = AW'(a); s1 = AW'(b); s2 = AW'(c); s3 = AW'(d);
        return {s3, s2, s1, s0};
    endfunction

    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_sel  = '0;
        wr_data = '0;
        rsv_en  = 1'b0;
        rsv_sel = '0;
        rsel    = p4(5, 7, 3, 9);
        model_reset();
        #2;
        push_exp();
        #10;
        rst_n = 1'b1;

        // Async reset mid-cycle after loading r5.
        cyc(1, 5, 32'hDEADBEEF, 0, 0, p4(5, 5, 1, 2), 0, 0);
        cyc(0, 0, 0, 1, 6, p4(5, 5, 1, 2), 0, 0);
        cyc(0, 0, 0, 0, 0, p4(5, 6, 5, 6), 1, 0);
        cyc(0, 0, 0, 0, 0, p4(5, 6, 5, 6), 0, 0);

        // Reserve / release of r7.
        cyc(0, 0, 0, 1, 7, p4(7, 7, 7, 7), 0, 0);
        cyc(1, 7, 32'h12345678, 0, 0, p4(7, 7, 7, 7), 0, 0);
        cyc(0, 0, 0, 0, 0, p4(7, 7, 7, 7), 0, 0);

        // Register 0 write + reserve.
        cyc(1, 0, 32'hFFFFFFFF, 1, 0, p4(0, 0, 0, 0), 0, 0);
        cyc(0, 0, 0, 0, 0, p4(0, 0, 0, 0), 0, 0);
        cyc(0, 0, 0, 0, 0, p4(0, 0, 0, 0), 0, 0);

        // Same-cycle write+reserve of busy r3, then WAW reserve.
        cyc(0, 0, 0, 1, 3, p4(3, 3, 3, 3), 0, 0);
        cyc(1, 3, 32'hA5A5A5A5, 1, 3, p4(3, 3, 3, 3), 0, 0);
        cyc(0, 0, 0, 1, 3, p4(3, 3, 3, 3), 0, 0);
        cyc(0, 0, 0, 0, 0, p4(3, 3, 3, 3), 0, 0);
        cyc(0, 0, 0, 0, 0, p4(3, 3, 3, 3), 0, 0);

        // Write-through check on port 1.
        cyc(1, 9, 32'h00000042, 0, 0, p4(1, 9, 9, 2), 0, 0);
        cyc(0, 0, 0, 0, 0, p4(1, 9, 9, 2), 0, 0);

        // All ports on r15, neighbour r14 untouched.
        cyc(1, 14, 32'h0BADF00D, 0, 0, p4(14, 15, 14, 15), 0, 0);
        cyc(1, 15, 32'h89ABCDEF, 0, 0, p4(15, 15, 15, 15), 0, 0);
        cyc(0, 0, 0, 0, 0, p4(15, 15, 15, 15), 0, 0);
        cyc(0, 0, 0, 0, 0, p4(14, 15, 14, 15), 0, 0);

        for (int n = 0; n < 600; n++) begin
            logic          we, re;
            logic [AW-1:0] ws, rs;
            logic [4*AW-1:0] rd;
            we = 1'($urandom_range(0, 1));
            re = 1'($urandom_range(0, 1));
            ws = AW'($urandom_range(0, NR - 1));
            rs = ($urandom_range(0, 3) == 0) ? ws
                 : AW'($urandom_range(0, NR - 1));
            rd = (4*AW)'($urandom);
            if ($urandom_range(0, 3) == 0) rd[AW +: AW] = ws;
            cyc(we, ws, $urandom, re, rs, rd,
                $urandom_range(0, 63) == 0, 1);
        end

        cyc(0, 0, 0, 0, 0, p4(1, 2, 3, 4), 0, 0);
        repeat (3) @(negedge clk);
        chk("drain", 128'(q.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
